// File: rtl/pseudo_clock_recovery.sv
// Recovers level, edge pulses, half-period, lock and loss-of-clock from an async pseudo-clock.
// Optional lock-break counter: define PSEUDO_CLOCK_GLITCH_CNT_EN.
module pseudo_clock_recovery #(
  parameter int C_SYNC_STAGES = 2,
  parameter int C_CNT_LEN     = 16,
  parameter int C_LOCK_COUNT  = 4,
  parameter int C_TOL         = 1,
  parameter int C_TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pseudoClkIn,
  output logic                 clkLevel,
  output logic                 rEdgePulse,
  output logic                 fEdgePulse,
  output logic [C_CNT_LEN-1:0] halfPeriod,
  output logic                 locked,
  output logic                 lost,
  output logic                 relockPulse,
  output logic [15:0]          glitchCount
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  localparam logic [C_CNT_LEN:0]   TOL_V     = (C_CNT_LEN+1)'(C_TOL);
  localparam logic [C_CNT_LEN-1:0] TIMEOUT_V = C_CNT_LEN'(C_TIMEOUT - 1);
  localparam logic [3:0]           LOCK_V    = 4'(C_LOCK_COUNT);

  logic [C_SYNC_STAGES-1:0] syncQ;
  logic                     lvlD;
  logic                     anyEdge;
  logic [C_CNT_LEN-1:0]     hpCnt;
  logic [C_CNT_LEN-1:0]     refHp;
  logic                     refValid;
  logic [3:0]               matchCnt;
  logic [C_CNT_LEN:0]       meas;
  logic [C_CNT_LEN:0]       refExt;
  logic [C_CNT_LEN:0]       absDiff;
  logic                     isMatch;
  logic                     timeoutHit;
  state_t                   state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncQ      <= '0;
      lvlD       <= 1'b0;
      rEdgePulse <= 1'b0;
      fEdgePulse <= 1'b0;
    end else begin
      syncQ      <= {syncQ[C_SYNC_STAGES-2:0], pseudoClkIn};
      lvlD       <= syncQ[C_SYNC_STAGES-1];
      rEdgePulse <= syncQ[C_SYNC_STAGES-1] & ~lvlD;
      fEdgePulse <= ~syncQ[C_SYNC_STAGES-1] & lvlD;
    end
  end

  assign clkLevel = syncQ[C_SYNC_STAGES-1];
  assign anyEdge  = rEdgePulse | fEdgePulse;

  // One extra bit so a saturated counter still measures without wrapping.
  assign meas       = {1'b0, hpCnt} + 1'b1;
  assign refExt     = {1'b0, refHp};
  assign absDiff    = (meas >= refExt) ? (meas - refExt) : (refExt - meas);
  assign isMatch    = (absDiff <= TOL_V);
  assign timeoutHit = (hpCnt == TIMEOUT_V) && !anyEdge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hpCnt       <= '0;
      refHp       <= '0;
      refValid    <= 1'b0;
      matchCnt    <= '0;
      halfPeriod  <= '0;
      locked      <= 1'b0;
      lost        <= 1'b0;
      relockPulse <= 1'b0;
    end else begin
      relockPulse <= 1'b0;
      if (anyEdge)          hpCnt <= '0;
      else if (hpCnt != '1) hpCnt <= hpCnt + 1'b1;

      case (state)
        IDLE: if (anyEdge) begin
          state    <= ACQUIRE;
          refValid <= 1'b0;
          matchCnt <= '0;
        end
        ACQUIRE: begin
          if (anyEdge) begin
            if (!refValid) begin
              refHp    <= meas[C_CNT_LEN-1:0];
              refValid <= 1'b1;
            end else if (isMatch) begin
              if (matchCnt + 4'd1 == LOCK_V) begin
                state      <= LOCKED;
                halfPeriod <= refHp;
                locked     <= 1'b1;
                matchCnt   <= '0;
              end else begin
                matchCnt <= matchCnt + 4'd1;
              end
            end else begin
              refHp    <= meas[C_CNT_LEN-1:0];
              matchCnt <= '0;
            end
          end else if (timeoutHit) begin
            state  <= LOST;
            lost   <= 1'b1;
            locked <= 1'b0;
          end
        end
        LOCKED: begin
          if (anyEdge) begin
            if (!isMatch) begin
              state       <= ACQUIRE;
              refHp       <= meas[C_CNT_LEN-1:0];
              refValid    <= 1'b1;
              matchCnt    <= '0;
              locked      <= 1'b0;
              relockPulse <= 1'b1;
            end
          end else if (timeoutHit) begin
            state  <= LOST;
            lost   <= 1'b1;
            locked <= 1'b0;
          end
        end
        LOST: if (anyEdge) begin
          // The first edge after a loss only restarts measurement.
          state    <= ACQUIRE;
          refValid <= 1'b0;
          matchCnt <= '0;
          lost     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSEUDO_CLOCK_GLITCH_CNT_EN
  logic leaveLocked;
  assign leaveLocked = (state == LOCKED) && (anyEdge ? !isMatch : timeoutHit);

  always_ff @(posedge clk) begin
    if (!rst)
      glitchCount <= '0;
    else if (leaveLocked && glitchCount != 16'hFFFF)
      glitchCount <= glitchCount + 16'd1;
  end
`else
  assign glitchCount = '0;
`endif

endmodule
